// File: rtl/reg_file32.sv
// reg_file32: 32-entry register file, two combinational read ports, one synchronous write port
//
// Ports:
//   clk      datapath clock, state updates on rising edge
//   rst      asynchronous active-high reset, clears every register
//   we       write enable, root enable of the one-hot write decode tree
//   waddr    write register index
//   wdata    write data
//   raddr_a  read port A index
//   raddr_b  read port B index
//   rdata_a  read port A data
//   rdata_b  read port B data
//
// Optional feature: define REGFILE_BYPASS_EN to forward wdata to a read port
// whose address matches a pending non-zero write in the same cycle.

module decoder1_to_2 (
    input  logic       en,
    input  logic       sel,
    output logic [1:0] y
);
    assign y = {en & sel, en & ~sel};
endmodule

module reg_file32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int N = 2 ** ADDR_W;
    // Decode tree stored heap-style: node k feeds children 2k+1 (sel=0) and
    // 2k+2 (sel=1); leaves N-1..2N-2 are the enables for registers 0..N-1,
    // because the MSB-first walk down the heap spells out the index.
    logic [2*N-2:0]    node;
    logic [N-1:0]      wen;
    logic              unused_wen0;
    logic [DATA_W-1:0] regs [1:N-1];
    logic [DATA_W-1:0] view [N];
    assign node[0] = we;
    for (genvar d = 0; d < ADDR_W; d++) begin : g_lvl
        for (genvar j = 0; j < 2 ** d; j++) begin : g_dec
            localparam int K = 2 ** d - 1 + j;
            decoder1_to_2 u_dec (
                .en (node[K]),
                .sel(waddr[ADDR_W-1-d]),
                .y  (node[2*K+2:2*K+1])
            );
        end
    end
    assign wen = node[2*N-2:N-1];
    // Register 0 has no storage, so its enable goes nowhere.
    assign unused_wen0 = wen[0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < N; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < N; i++) if (wen[i]) regs[i] <= wdata;
        end
    end
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < N; i++) view[i] = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok  = we && !rst && (waddr != '0);
    assign rdata_a = (fwd_ok && raddr_a == waddr) ? wdata : view[raddr_a];
    assign rdata_b = (fwd_ok && raddr_b == waddr) ? wdata : view[raddr_b];
`else
    assign rdata_a = view[raddr_a];
    assign rdata_b = view[raddr_b];
`endif
endmodule

// File: tb/tb_reg_file32.sv
// tb_reg_file32: directed and randomized checks of reg_file32 against an array model
module tb_reg_file32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [31:0] model [32];
    int tests = 0;
    int fails = 0;

    reg_file32 dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expect_rd(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && waddr != 0 && ra == waddr) return wdata;
`endif
        return (ra == 0) ? 32'h0 : model[ra];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // One cycle: drive after the falling edge, check before and after the rising edge.
    task automatic cyc(input string tag, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        #1;
        chk({tag, " pre A"}, rdata_a, expect_rd(ra));
        chk({tag, " pre B"}, rdata_b, expect_rd(rb));
        @(posedge clk);
        if (rst) clear_model();
        else if (w && wa != 0) model[wa] = wd;
        #1;
        chk({tag, " post A"}, rdata_a, expect_rd(ra));
        chk({tag, " post B"}, rdata_b, expect_rd(rb));
    endtask

    initial begin
        clear_model();
        #1;
        chk("reset A", rdata_a, 32'h0);
        raddr_b = 5'd17;
        #1;
        chk("reset B", rdata_b, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // fill then asynchronous reset mid-cycle
        for (int i = 1; i < 32; i++) cyc("fill", 1'b1, 5'(i), 32'hA5A5_0000 + i, 5'(i), 5'(32 - i));
        @(negedge clk);
        we = 1'b0; raddr_a = 5'd1; raddr_b = 5'd31;
        #1;
        chk("prefill A", rdata_a, 32'hA5A5_0001);
        #1;
        rst = 1'b1;
        clear_model();
        #1;
        chk("async rst A", rdata_a, 32'h0);
        chk("async rst B", rdata_b, 32'h0);
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(31 - i);
            #1;
            chk("rst sweep A", rdata_a, 32'h0);
            chk("rst sweep B", rdata_b, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        // write/read sweep
        for (int i = 1; i < 32; i++) cyc("sweep wr", 1'b1, 5'(i), 32'h1000_0000 + i, 5'd0, 5'(i));
        @(negedge clk);
        we = 1'b0;
        for (int i = 1; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(32 - i);
            #0.2;
            chk("sweep A", rdata_a, 32'h1000_0000 + i);
            chk("sweep B", rdata_b, 32'h1000_0000 + 32 - i);
        end
        // register 0, write disabled, same-cycle hazard
        cyc("reg0", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        chk("reg0 const", rdata_a, 32'h0);
        cyc("we0", 1'b0, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
        chk("we0 const", rdata_a, 32'h1000_0007);
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr_a = 5'd5; raddr_b = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("hazard pre A", rdata_a, 32'h1234_5678);
        chk("hazard pre B", rdata_b, 32'h1234_5678);
`else
        chk("hazard pre A", rdata_a, 32'h1000_0005);
        chk("hazard pre B", rdata_b, 32'h1000_0005);
`endif
        @(posedge clk);
        model[5] = 32'h1234_5678;
        #1;
        chk("hazard post A", rdata_a, 32'h1234_5678);
        chk("hazard post B", rdata_b, 32'h1234_5678);
        // we pulsing between edges must not write
        @(negedge clk);
        we = 1'b0; waddr = 5'd9; wdata = 32'h0BAD_0BAD; raddr_a = 5'd9;
        #1 we = 1'b1;
        #1 we = 1'b0;
        @(posedge clk);
        #1;
        chk("we glitch", rdata_a, 32'h1000_0009);
        // back-to-back writes to the same register
        for (int i = 0; i < 4; i++) cyc("b2b", 1'b1, 5'd9, 32'h9000_0000 + i, 5'd9, 5'd10);
        chk("b2b last", rdata_a, 32'h9000_0003);
        // reset held across a write edge
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D; raddr_a = 5'd3;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        #1;
        chk("rst write lost", rdata_a, 32'h0);
        // first edge after deassertion writes
        cyc("post rst wr", 1'b1, 5'd3, 32'h3333_3333, 5'd3, 5'd4);
        // randomized traffic
        for (int n = 0; n < 400; n++)
            cyc("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
